// File: rtl/scan_timing_gen.sv
// rtl/scan_timing_gen.sv - raster scan counters with registered sync/video/pixel stage and frame/vblank ticks
module scan_timing_gen #(
    parameter int H_ACTIVE        = 640,
    parameter int H_FP            = 16,
    parameter int H_SYNC          = 96,
    parameter int H_BP            = 48,
    parameter int V_ACTIVE        = 480,
    parameter int V_FP            = 10,
    parameter int V_SYNC          = 2,
    parameter int V_BP            = 33,
    parameter int SYNC_ACTIVE_LOW = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pix_en,
    input  logic        graphics,
    output logic [15:0] scan_x,
    output logic [15:0] scan_y,
    output logic        hsync,
    output logic        vsync,
    output logic        video_on,
    output logic        pixel,
    output logic        frame_tick,
    output logic        vblank_tick
);

    localparam logic [15:0] H_ACT    = 16'(H_ACTIVE);
    localparam logic [15:0] H_TOTAL  = 16'(H_ACTIVE + H_FP + H_SYNC + H_BP);
    localparam logic [15:0] HS_START = 16'(H_ACTIVE + H_FP);
    localparam logic [15:0] HS_END   = 16'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [15:0] V_ACT    = 16'(V_ACTIVE);
    localparam logic [15:0] V_TOTAL  = 16'(V_ACTIVE + V_FP + V_SYNC + V_BP);
    localparam logic [15:0] VS_START = 16'(V_ACTIVE + V_FP);
    localparam logic [15:0] VS_END   = 16'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic        SYNC_INV = (SYNC_ACTIVE_LOW != 0);

    logic [15:0] h_q, h_d, v_q, v_d;
    logic        hsync_q, hsync_d, vsync_q, vsync_d;
    logic        video_q, video_d, pixel_q, pixel_d;
    logic        frame_q, frame_d, vblank_q, vblank_d;
    logic        h_wrap, v_wrap, active, hs, vs;

    always_comb begin
        h_wrap = (h_q == H_TOTAL - 16'd1);
        v_wrap = (v_q == V_TOTAL - 16'd1);
        active = (h_q < H_ACT) && (v_q < V_ACT);
        hs     = (h_q >= HS_START) && (h_q < HS_END);
        vs     = (v_q >= VS_START) && (v_q < VS_END);
    end

    // Ticks default low every clk so they last one cycle even across a pix_en stall.
    always_comb begin
        h_d      = h_q;
        v_d      = v_q;
        hsync_d  = hsync_q;
        vsync_d  = vsync_q;
        video_d  = video_q;
        pixel_d  = pixel_q;
        frame_d  = 1'b0;
        vblank_d = 1'b0;
        if (pix_en) begin
            h_d = h_wrap ? 16'd0 : h_q + 16'd1;
            if (h_wrap) begin
                v_d = v_wrap ? 16'd0 : v_q + 16'd1;
            end
            hsync_d  = hs ^ SYNC_INV;
            vsync_d  = vs ^ SYNC_INV;
            video_d  = active;
            pixel_d  = active & graphics;
            frame_d  = h_wrap && v_wrap;
            vblank_d = h_wrap && (v_q == V_ACT - 16'd1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            h_q      <= 16'd0;
            v_q      <= 16'd0;
            hsync_q  <= SYNC_INV;
            vsync_q  <= SYNC_INV;
            video_q  <= 1'b0;
            pixel_q  <= 1'b0;
            frame_q  <= 1'b0;
            vblank_q <= 1'b0;
        end else begin
            h_q      <= h_d;
            v_q      <= v_d;
            hsync_q  <= hsync_d;
            vsync_q  <= vsync_d;
            video_q  <= video_d;
            pixel_q  <= pixel_d;
            frame_q  <= frame_d;
            vblank_q <= vblank_d;
        end
    end

    assign scan_x      = h_q;
    assign scan_y      = v_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign video_on    = video_q;
    assign pixel       = pixel_q;
    assign frame_tick  = frame_q;
    assign vblank_tick = vblank_q;

endmodule

// File: tb/tb_scan_timing_gen.sv
// tb/tb_scan_timing_gen.sv - scoreboard bench for scan_timing_gen on a reduced raster
module tb_scan_timing_gen;

    localparam int HA = 16, HFP = 2, HS = 3, HBP = 2;
    localparam int VA = 8,  VFP = 2, VS = 2, VBP = 3;
    localparam int HT = HA + HFP + HS + HBP;
    localparam int VT = VA + VFP + VS + VBP;
    localparam int FRAME = HT * VT;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        pix_en = 1'b0;
    logic        graphics = 1'b0;
    logic [15:0] scan_x, scan_y;
    logic        hsync, vsync, video_on, pixel, frame_tick, vblank_tick;

    scan_timing_gen #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
        .SYNC_ACTIVE_LOW(1)
    ) dut (
        .clk(clk), .rst(rst), .pix_en(pix_en), .graphics(graphics),
        .scan_x(scan_x), .scan_y(scan_y), .hsync(hsync), .vsync(vsync),
        .video_on(video_on), .pixel(pixel), .frame_tick(frame_tick),
        .vblank_tick(vblank_tick)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_total = 0;
    logic [37:0] exp_q[$];
    logic [37:0] got, exp_v;

    // Reference state: coordinates and the output registers as they should read after the next edge.
    int   mx = 0, my = 0;
    logic e_hs = 1, e_vs = 1, e_vid = 0, e_pix = 0, e_ft = 0, e_vt = 0;

    task automatic drive(input logic r, input logic en, input logic g);
        rst = r;
        pix_en = en;
        graphics = g;
        if (r) begin
            mx = 0; my = 0;
            e_hs = 1; e_vs = 1; e_vid = 0; e_pix = 0; e_ft = 0; e_vt = 0;
        end else begin
            e_ft = 0;
            e_vt = 0;
            if (en) begin
                e_vid = (mx < HA) && (my < VA);
                e_pix = e_vid && g;
                e_hs  = !((mx >= HA + HFP) && (mx < HA + HFP + HS));
                e_vs  = !((my >= VA + VFP) && (my < VA + VFP + VS));
                if (mx == HT - 1) begin
                    mx = 0;
                    if (my == VT - 1) begin
                        my = 0;
                        e_ft = 1;
                    end else begin
                        if (my == VA - 1) e_vt = 1;
                        my = my + 1;
                    end
                end else begin
                    mx = mx + 1;
                end
            end
        end
        exp_q.push_back({16'(mx), 16'(my), e_hs, e_vs, e_vid, e_pix, e_ft, e_vt});
        @(posedge clk);
        #1;
    endtask

    function automatic logic [37:0] dut_vec();
        return {scan_x, scan_y, hsync, vsync, video_on, pixel, frame_tick, vblank_tick};
    endfunction

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            drive(1, 1, 1);
            got = dut_vec(); exp_v = exp_q.pop_front(); n_total++;
            if (got !== exp_v) $display("FAIL reset[%0d] got=%h exp=%h", i, got, exp_v);
            else n_pass++;
        end
        drive(0, 1, 0);
        got = dut_vec(); exp_v = exp_q.pop_front(); n_total++;
        if (got !== exp_v) $display("FAIL reset_release got=%h exp=%h", got, exp_v);
        else n_pass++;
        n_total++;
        if (scan_x !== 16'd1) $display("FAIL reset_first_x got=%0d exp=1", scan_x);
        else n_pass++;
    endtask

    task automatic test_horizontal();
        int hs_low = 0;
        drive(1, 1, 0);
        void'(exp_q.pop_front());
        for (int i = 0; i < 2 * HT + 3; i++) begin
            drive(0, 1, 0);
            got = dut_vec(); exp_v = exp_q.pop_front(); n_total++;
            if (got !== exp_v) $display("FAIL horiz[%0d] got=%h exp=%h", i, got, exp_v);
            else n_pass++;
            if (i >= 1 && i <= HT && hsync === 1'b0) hs_low++;
        end
        n_total++;
        if (hs_low != HS) $display("FAIL horiz_hsync_width got=%0d exp=%0d", hs_low, HS);
        else n_pass++;
        n_total++;
        if (scan_y !== 16'd2) $display("FAIL horiz_line_step got=%0d exp=2", scan_y);
        else n_pass++;
    endtask

    task automatic test_frame_ticks();
        int ft_cnt = 0, vt_cnt = 0, ft_first = -1, ft_last = -1;
        drive(1, 1, 0);
        void'(exp_q.pop_front());
        for (int i = 0; i < 2 * FRAME + 4; i++) begin
            drive(0, 1, 1'($urandom_range(0, 1)));
            got = dut_vec(); exp_v = exp_q.pop_front(); n_total++;
            if (got !== exp_v) $display("FAIL frame[%0d] got=%h exp=%h", i, got, exp_v);
            else n_pass++;
            if (frame_tick === 1'b1) begin
                ft_cnt++;
                if (ft_first < 0) ft_first = i;
                ft_last = i;
                if (scan_x !== 0 || scan_y !== 0) $display("FAIL frame_tick_pos got=(%0d,%0d) exp=(0,0)", scan_x, scan_y);
            end
            if (vblank_tick === 1'b1) begin
                vt_cnt++;
                if (scan_x !== 0 || scan_y !== VA) $display("FAIL vblank_tick_pos got=(%0d,%0d) exp=(0,%0d)", scan_x, scan_y, VA);
            end
        end
        n_total++;
        if (ft_cnt != 2) $display("FAIL frame_tick_count got=%0d exp=2", ft_cnt);
        else n_pass++;
        n_total++;
        if (ft_last - ft_first != FRAME) $display("FAIL frame_tick_period got=%0d exp=%0d", ft_last - ft_first, FRAME);
        else n_pass++;
        n_total++;
        if (vt_cnt != 2) $display("FAIL vblank_tick_count got=%0d exp=2", vt_cnt);
        else n_pass++;
    endtask

    task automatic test_pixel_gating();
        int pix_hi = 0, pulses = 0;
        drive(1, 1, 0);
        void'(exp_q.pop_front());
        for (int i = 0; i < FRAME; i++) begin
            drive(0, 1, 1);
            got = dut_vec(); exp_v = exp_q.pop_front(); n_total++;
            if (got !== exp_v) $display("FAIL gate_const[%0d] got=%h exp=%h", i, got, exp_v);
            else n_pass++;
            if (pixel === 1'b1) pix_hi++;
        end
        n_total++;
        if (pix_hi != HA * VA) $display("FAIL gate_const_count got=%0d exp=%0d", pix_hi, HA * VA);
        else n_pass++;
        for (int i = 0; i < FRAME; i++) begin
            drive(0, 1, (mx == 10 && my == 5));
            got = dut_vec(); exp_v = exp_q.pop_front(); n_total++;
            if (got !== exp_v) $display("FAIL gate_point[%0d] got=%h exp=%h", i, got, exp_v);
            else n_pass++;
            if (pixel === 1'b1) pulses++;
        end
        n_total++;
        if (pulses != 1) $display("FAIL gate_point_count got=%0d exp=1", pulses);
        else n_pass++;
    endtask

    task automatic test_stall();
        int guard = 0, ft_hi = 0;
        for (int i = 0; i < FRAME; i++) begin
            drive(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            got = dut_vec(); exp_v = exp_q.pop_front(); n_total++;
            if (got !== exp_v) $display("FAIL stall[%0d] got=%h exp=%h", i, got, exp_v);
            else n_pass++;
        end
        while (!(mx == HT - 1 && my == VT - 1) && guard < 2 * FRAME) begin
            drive(0, 1, 0);
            void'(exp_q.pop_front());
            guard++;
        end
        n_total++;
        if (guard >= 2 * FRAME) $display("FAIL stall_seek got=timeout exp=frame_end");
        else n_pass++;
        drive(0, 1, 0);
        for (int i = 0; i < 6; i++) begin
            if (i > 0) drive(0, 0, 1);
            got = dut_vec(); exp_v = exp_q.pop_front(); n_total++;
            if (got !== exp_v) $display("FAIL stall_tick[%0d] got=%h exp=%h", i, got, exp_v);
            else n_pass++;
            if (frame_tick === 1'b1) ft_hi++;
        end
        n_total++;
        if (ft_hi != 1) $display("FAIL stall_tick_width got=%0d exp=1", ft_hi);
        else n_pass++;
    endtask

    task automatic test_mid_reset();
        int guard = 0;
        while (!(mx == 10 && my == 6) && guard < 2 * FRAME) begin
            drive(0, 1, 1);
            void'(exp_q.pop_front());
            guard++;
        end
        n_total++;
        if (scan_x !== 16'd10 || scan_y !== 16'd6) $display("FAIL midrst_seek got=(%0d,%0d) exp=(10,6)", scan_x, scan_y);
        else n_pass++;
        drive(1, 1, 1);
        got = dut_vec(); exp_v = exp_q.pop_front(); n_total++;
        if (got !== exp_v) $display("FAIL midrst_state got=%h exp=%h", got, exp_v);
        else n_pass++;
        for (int i = 0; i < HT + 2; i++) begin
            drive(0, 1, 1);
            got = dut_vec(); exp_v = exp_q.pop_front(); n_total++;
            if (got !== exp_v) $display("FAIL midrst_run[%0d] got=%h exp=%h", i, got, exp_v);
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_horizontal();
        test_frame_ticks();
        test_pixel_gating();
        test_stall();
        test_mid_reset();
        n_total++;
        if (exp_q.size() != 0) $display("FAIL scoreboard_leftover got=%0d exp=0", exp_q.size());
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
